// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller between instruction fetch and load/store.
// Optional `STARVE_GUARD_EN: after STARVE_LIMIT MEM grants while a fetch waits, the fetch is forced through.
module mem_arbiter
`ifdef STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_mask,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [1:0]  mc_mask,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_IF  = 2'd1;
  localparam logic [1:0] GNT_MEM = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]  state_q,     state_d;
  logic        mcReq_q,     mcReq_d;
  logic        mcWe_q,      mcWe_d;
  logic [31:0] mcAddr_q,    mcAddr_d;
  logic [31:0] mcWdata_q,   mcWdata_d;
  logic [1:0]  mcMask_q,    mcMask_d;
  logic        ifDone_q,    ifDone_d;
  logic [31:0] ifInst_q,    ifInst_d;
  logic        memDone_q,   memDone_d;
  logic [31:0] memRdata_q,  memRdata_d;
  logic        flushPend_q, flushPend_d;
`ifdef STARVE_GUARD_EN
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
`endif

  logic flushEff;
  logic forceIf;

  // Everything holds while rdy_in is low except the done pulses, which always fall after one cycle.
  // A flush seen during a pause is parked in flushPend_q and acts on the first ready cycle.
  always_comb begin
    state_d     = state_q;
    mcReq_d     = mcReq_q;
    mcWe_d      = mcWe_q;
    mcAddr_d    = mcAddr_q;
    mcWdata_d   = mcWdata_q;
    mcMask_d    = mcMask_q;
    ifDone_d    = 1'b0;
    ifInst_d    = ifInst_q;
    memDone_d   = 1'b0;
    memRdata_d  = memRdata_q;
    flushPend_d = flushPend_q;
    flushEff    = if_flush | flushPend_q;
    forceIf     = 1'b0;
`ifdef STARVE_GUARD_EN
    starveCnt_d = starveCnt_q;
    forceIf     = (starveCnt_q == CNT_W'(STARVE_LIMIT)) && if_req && !flushEff;
`endif
    if (!rdy_in) begin
      flushPend_d = flushPend_q | if_flush;
    end else begin
      flushPend_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req && !forceIf) begin
            state_d   = GNT_MEM;
            mcReq_d   = 1'b1;
            mcWe_d    = mem_we;
            mcAddr_d  = mem_addr;
            mcWdata_d = mem_wdata;
            mcMask_d  = mem_mask;
          end else if (if_req && !flushEff) begin
            state_d   = GNT_IF;
            mcReq_d   = 1'b1;
            mcWe_d    = 1'b0;
            mcAddr_d  = if_addr;
            mcWdata_d = 32'h0;
            mcMask_d  = 2'b11;
          end
        end
        GNT_IF: begin
          if (mc_done) begin
            mcReq_d = 1'b0;
            state_d = IDLE;
            if (!flushEff) begin
              ifDone_d = 1'b1;
              ifInst_d = mc_rdata;
            end
          end else if (flushEff) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mc_done) begin
            mcReq_d = 1'b0;
            state_d = IDLE;
          end
        end
        GNT_MEM: begin
          if (mc_done) begin
            mcReq_d    = 1'b0;
            state_d    = IDLE;
            memDone_d  = 1'b1;
            memRdata_d = mcWe_q ? 32'h0 : mc_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef STARVE_GUARD_EN
      // Count MEM grants that overtook a waiting fetch; any fetch grant or idle-without-fetch resets it.
      if (state_q == IDLE) begin
        if (!if_req) begin
          starveCnt_d = '0;
        end else if (mem_req && !forceIf) begin
          if (starveCnt_q != CNT_W'(STARVE_LIMIT)) starveCnt_d = starveCnt_q + 1'b1;
        end else if (!flushEff) begin
          starveCnt_d = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcReq_q     <= 1'b0;
      mcWe_q      <= 1'b0;
      mcAddr_q    <= 32'h0;
      mcWdata_q   <= 32'h0;
      mcMask_q    <= 2'b00;
      ifDone_q    <= 1'b0;
      ifInst_q    <= 32'h0;
      memDone_q   <= 1'b0;
      memRdata_q  <= 32'h0;
      flushPend_q <= 1'b0;
`ifdef STARVE_GUARD_EN
      starveCnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mcReq_q     <= mcReq_d;
      mcWe_q      <= mcWe_d;
      mcAddr_q    <= mcAddr_d;
      mcWdata_q   <= mcWdata_d;
      mcMask_q    <= mcMask_d;
      ifDone_q    <= ifDone_d;
      ifInst_q    <= ifInst_d;
      memDone_q   <= memDone_d;
      memRdata_q  <= memRdata_d;
      flushPend_q <= flushPend_d;
`ifdef STARVE_GUARD_EN
      starveCnt_q <= starveCnt_d;
`endif
    end
  end

  assign mc_req    = mcReq_q;
  assign mc_we     = mcWe_q;
  assign mc_addr   = mcAddr_q;
  assign mc_wdata  = mcWdata_q;
  assign mc_mask   = mcMask_q;
  assign if_done   = ifDone_q;
  assign if_inst   = ifInst_q;
  assign mem_done  = memDone_q;
  assign mem_rdata = memRdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model.
// Build with or without +define+STARVE_GUARD_EN; the model follows the same macro.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int OWN_NONE  = 0;
  localparam int OWN_FETCH = 1;
  localparam int OWN_MEM   = 2;
  localparam int OWN_DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst, rdy_in;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_mask, mc_mask;
  logic        mc_req, mc_we, mc_done, busy;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_mask(mc_mask),
    .mc_done(mc_done), .mc_rdata(mc_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the controller, what was latched, and which pulse is due.
  int          owner;
  logic        mWe, mIfDone, mMemDone, mFlushPend;
  logic [31:0] mAddr, mWdata, mIfInst, mMemRdata;
  logic [1:0]  mMask;
  int          mStarve;

  // Controller and requester behaviour.
  logic        ctrlBusy, ctrlFixed, randMode, contIf, contMem;
  int          ctrlWait, ctrlLat, pauseCycles, seq, cycleNo;
  logic [31:0] ctrlData;

  // Observation logs.
  int          ifDoneCnt, memDoneCnt, memDoneCycle;
  logic [31:0] lastIfInst, lastMemRdata;
  logic        prevMcReq;
  logic [31:0] grantLog[$];
  int          grantCycle[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleNo);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    logic flush, starveForce, ifWins;
    if (rst) begin
      owner = OWN_NONE; mWe = 0; mAddr = 0; mWdata = 0; mMask = 0;
      mIfDone = 0; mMemDone = 0; mIfInst = 0; mMemRdata = 0; mFlushPend = 0; mStarve = 0;
      return;
    end
    mIfDone  = 0;
    mMemDone = 0;
    if (!rdy_in) begin
      mFlushPend = mFlushPend | if_flush;
      return;
    end
    flush = if_flush | mFlushPend;
    mFlushPend = 0;
`ifdef STARVE_GUARD_EN
    starveForce = (mStarve >= STARVE_LIMIT);
`else
    starveForce = 0;
`endif
    case (owner)
      OWN_NONE: begin
        ifWins = if_req && !flush && (!mem_req || starveForce);
        if (mem_req && !ifWins) begin
          owner = OWN_MEM; mWe = mem_we; mAddr = mem_addr; mWdata = mem_wdata; mMask = mem_mask;
          mStarve = if_req ? ((mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve) : 0;
        end else if (ifWins) begin
          owner = OWN_FETCH; mWe = 0; mAddr = if_addr; mWdata = 0; mMask = 2'b11;
          mStarve = 0;
        end else if (!if_req) begin
          mStarve = 0;
        end
      end
      OWN_FETCH: begin
        if (mc_done) begin
          owner = OWN_NONE;
          if (!flush) begin mIfDone = 1; mIfInst = mc_rdata; end
        end else if (flush) begin
          owner = OWN_DRAIN;
        end
      end
      OWN_DRAIN: if (mc_done) owner = OWN_NONE;
      default: begin
        if (mc_done) begin
          owner = OWN_NONE; mMemDone = 1; mMemRdata = mWe ? 32'h0 : mc_rdata;
        end
      end
    endcase
  endtask

  task automatic checkCycle();
    logic active;
    active = (owner != OWN_NONE);
    checkOutput("mc_req", 32'(mc_req), 32'(active));
    checkOutput("busy", 32'(busy), 32'(active));
    if (active) begin
      checkOutput("mc_addr", mc_addr, mAddr);
      checkOutput("mc_we", 32'(mc_we), 32'(mWe));
      checkOutput("mc_mask", 32'(mc_mask), 32'(mMask));
      if (mWe) checkOutput("mc_wdata", mc_wdata, mWdata);
    end
    checkOutput("if_done", 32'(if_done), 32'(mIfDone));
    checkOutput("mem_done", 32'(mem_done), 32'(mMemDone));
    if (mIfDone) checkOutput("if_inst", if_inst, mIfInst);
    if (mMemDone) checkOutput("mem_rdata", mem_rdata, mMemRdata);
  endtask

  // Controller: answers once per transaction after a latency, never while paused.
  task automatic driveController();
    if (mc_done) begin
      mc_done  = 1'b0;
      ctrlBusy = 1'b0;
    end
    mc_rdata = $urandom;
    if (!ctrlBusy && mc_req) begin
      ctrlBusy = 1'b1;
      ctrlWait = randMode ? int'($urandom_range(0, 4)) : ctrlLat;
    end
    if (ctrlBusy && rdy_in) begin
      if (ctrlWait == 0) begin
        mc_done  = 1'b1;
        mc_rdata = ctrlFixed ? ctrlData : $urandom;
      end else begin
        ctrlWait--;
      end
    end
  endtask

  // Requesters: drop on done, optionally re-request continuously or at random.
  task automatic applyStimulus();
    if_flush = 1'b0;
    if (if_done) if_req = 1'b0;
    if (mem_done) mem_req = 1'b0;
    if (contIf && !if_req) begin
      if_req = 1'b1; if_addr = 32'h1000 + 32'(seq * 4); seq++;
    end
    if (contMem && !mem_req) begin
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0000 + 32'(seq * 4); mem_mask = 2'b01; seq++;
    end
    if (randMode) begin
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = {16'h0, 16'($urandom)};
      end
      if (!mem_req && $urandom_range(0, 3) == 0) begin
        mem_req = 1'b1; mem_we = 1'($urandom); mem_addr = 32'h8000_0000 | {16'h0, 16'($urandom)};
        mem_wdata = $urandom; mem_mask = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 15) == 0) begin
        if_flush = 1'b1; if_req = 1'($urandom); if_addr = {16'h0, 16'($urandom)};
      end
    end
    if (pauseCycles > 0) begin
      rdy_in = 1'b0; pauseCycles--;
    end else if (randMode) begin
      rdy_in = ($urandom_range(0, 5) != 0);
    end else begin
      rdy_in = 1'b1;
    end
    driveController();
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    cycleNo++;
    checkCycle();
    if (if_done) begin ifDoneCnt++; lastIfInst = if_inst; end
    if (mem_done) begin memDoneCnt++; lastMemRdata = mem_rdata; memDoneCycle = cycleNo; end
    if (mc_req && !prevMcReq) begin grantLog.push_back(mc_addr); grantCycle.push_back(cycleNo); end
    prevMcReq = mc_req;
    applyStimulus();
  endtask

  task automatic clearLogs();
    ifDoneCnt = 0; memDoneCnt = 0; memDoneCycle = -1;
    lastIfInst = 32'hx; lastMemRdata = 32'hx;
    grantLog.delete(); grantCycle.delete();
  endtask

  function automatic logic quiet();
    return !if_req && !mem_req && !mc_req && !busy && !if_done && !mem_done;
  endfunction

  task automatic runUntilQuiet(input int maxCycles);
    for (int i = 0; i < maxCycles && !quiet(); i++) step();
    checkOutput("quiet_timeout", 32'(quiet()), 32'd1);
  endtask

  task automatic resetDut();
    rst = 1'b1; rdy_in = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_mask = 0;
    mc_done = 0; mc_rdata = 0; ctrlBusy = 0; ctrlFixed = 0; ctrlData = 0; ctrlLat = 3;
    randMode = 0; contIf = 0; contMem = 0; pauseCycles = 0; prevMcReq = 0;
    step();
    step();
    rst = 1'b0;
    clearLogs();
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic expIf;
    cycleNo = 0; seq = 0; ctrlWait = 0;

    // Reset state
    resetDut();
    checkOutput("rst_mc_req", 32'(mc_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mc_addr", mc_addr, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
    checkOutput("rst_dones", {30'd0, if_done, mem_done}, 32'd0);

    // Fetch only
    $display("[TB] fetch only");
    ctrlFixed = 1; ctrlData = 32'h0000_0013; ctrlLat = 5;
    if_req = 1; if_addr = 32'h100;
    step();
    checkOutput("fetch_addr", mc_addr, 32'h100);
    checkOutput("fetch_mask", 32'(mc_mask), 32'd3);
    runUntilQuiet(50);
    checkOutput("fetch_done_cnt", 32'(ifDoneCnt), 32'd1);
    checkOutput("fetch_inst", lastIfInst, 32'h0000_0013);
    checkOutput("fetch_no_mem_done", 32'(memDoneCnt), 32'd0);
    ctrlFixed = 0;

    // Simultaneous requests: MEM first, IF one cycle after mem_done
    $display("[TB] simultaneous");
    clearLogs(); ctrlLat = 2;
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_mask = 2'b01;
    step();
    checkOutput("simul_first", mc_addr, 32'h2000);
    runUntilQuiet(50);
    checkOutput("simul_grants", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() >= 2) begin
      checkOutput("simul_second", grantLog[1], 32'h104);
      checkOutput("simul_gap", 32'(grantCycle[1]), 32'(memDoneCycle + 1));
    end

    // Store, requester changes its inputs after the grant
    $display("[TB] store");
    clearLogs(); ctrlLat = 4;
    mem_req = 1; mem_we = 1; mem_addr = 32'h30004; mem_wdata = 32'hDEADBEEF; mem_mask = 2'b11;
    step();
    checkOutput("store_we", 32'(mc_we), 32'd1);
    checkOutput("store_wdata", mc_wdata, 32'hDEADBEEF);
    mem_req = 0; mem_addr = 32'h5555; mem_wdata = 32'h1234; mem_we = 0;
    runUntilQuiet(50);
    checkOutput("store_done_cnt", 32'(memDoneCnt), 32'd1);
    checkOutput("store_rdata", lastMemRdata, 32'd0);

    // Flush of an in-flight fetch, then a normal fetch
    $display("[TB] flush in flight");
    clearLogs(); ctrlLat = 4;
    if_req = 1; if_addr = 32'h180;
    step();
    step();
    if_flush = 1; if_req = 0;
    runUntilQuiet(50);
    checkOutput("flush_no_done", 32'(ifDoneCnt), 32'd0);
    if_req = 1; if_addr = 32'h200;
    step();
    checkOutput("refetch_addr", mc_addr, 32'h200);
    runUntilQuiet(50);
    checkOutput("refetch_done_cnt", 32'(ifDoneCnt), 32'd1);

    // Pause during a load
    $display("[TB] pause during load");
    clearLogs(); ctrlLat = 6;
    mem_req = 1; mem_we = 0; mem_addr = 32'h4000; mem_mask = 2'b10;
    step();
    pauseCycles = 3;
    step();
    if_flush = 1;
    step();
    step();
    checkOutput("pause_mem_addr", mc_addr, 32'h4000);
    checkOutput("pause_mem_busy", 32'(busy), 32'd1);
    runUntilQuiet(50);
    checkOutput("pause_mem_done_cnt", 32'(memDoneCnt), 32'd1);

    // Pause during a fetch with a flush parked in the pause
    $display("[TB] pause with flush during fetch");
    clearLogs(); ctrlLat = 6;
    if_req = 1; if_addr = 32'h240;
    step();
    pauseCycles = 3;
    step();
    if_flush = 1; if_req = 0;
    step();
    checkOutput("pause_if_addr", mc_addr, 32'h240);
    checkOutput("pause_if_busy", 32'(busy), 32'd1);
    runUntilQuiet(50);
    checkOutput("pause_flush_no_done", 32'(ifDoneCnt), 32'd0);

    // Continuous MEM traffic with a waiting fetch
    $display("[TB] starvation");
    resetDut();
    ctrlLat = 1; contIf = 1; contMem = 1;
    if_req = 1; if_addr = 32'h1000;
    mem_req = 1; mem_we = 0; mem_addr = 32'h8000_0000; mem_mask = 2'b01;
    for (int i = 0; i < 400 && grantLog.size() < 10; i++) step();
    checkOutput("starve_grant_cnt", 32'(grantLog.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grantLog.size(); i++) begin
`ifdef STARVE_GUARD_EN
      expIf = (i % 5 == 4);
`else
      expIf = 1'b0;
`endif
      checkOutput($sformatf("starve_kind%0d", i), 32'(!grantLog[i][31]), 32'(expIf));
    end
    contIf = 0; contMem = 0;
    runUntilQuiet(100);

    // Randomized traffic with pauses and flushes
    $display("[TB] random traffic");
    resetDut();
    randMode = 1;
    for (int i = 0; i < 3000; i++) step();
    randMode = 0;
    runUntilQuiet(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
